axi_port_mux: RTL and testbench

AXI_PORT_MUX -- requirements
Module: axi_port_mux

---
 rtl/axi_port_mux.sv | 172 +++++++++++++++++
 tb/tb_axi_port_mux.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_port_mux.sv
// Binds each upstream AXI master to one downstream NI port on request and routes its
// traffic there; outstanding writes/reads are tracked so a port is released only once drained.
module axi_port_mux #(
    parameter int NOC_SIZE   = 4,
    parameter int N_MST      = 2,
    parameter int N_SLV      = NOC_SIZE,
    parameter int MAX_OUTSTD = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    localparam int SEL_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1,
    localparam int MOSI_W = 2 * ADDR_W + DATA_W + 6,
    localparam int MISO_W = DATA_W + 8
) (
    input  logic                    clk_axi,
    input  logic                    arst_axi,
    input  logic [N_MST-1:0]        act_i,
    input  logic [N_MST*SEL_W-1:0]  sel_i,
    input  logic [N_MST*MOSI_W-1:0] m_mosi_i,
    output logic [N_MST*MISO_W-1:0] m_miso_o,
    output logic [N_SLV*MOSI_W-1:0] s_mosi_o,
    input  logic [N_SLV*MISO_W-1:0] s_miso_i,
    output logic [N_MST-1:0]        bound_o,
    output logic [N_MST-1:0]        conflict_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTD);

    // mosi: {awvalid, awaddr, wvalid, wdata, wlast, bready, arvalid, araddr, rready}
    // miso: {awready, wready, bvalid, bresp[1:0], arready, rvalid, rdata, rlast}
    localparam int M_RREADY  = 0;
    localparam int M_ARVALID = ADDR_W + 1;
    localparam int M_BREADY  = ADDR_W + 2;
    localparam int M_AWVALID = 2 * ADDR_W + DATA_W + 5;
    localparam int S_RLAST   = 0;
    localparam int S_RVALID  = DATA_W + 1;
    localparam int S_ARREADY = DATA_W + 2;
    localparam int S_BVALID  = DATA_W + 5;
    localparam int S_AWREADY = DATA_W + 7;

    typedef enum logic [1:0] {IDLE, BOUND, DRAIN} state_t;

    state_t           state_reg   [N_MST];
    state_t           state_next  [N_MST];
    logic [SEL_W-1:0] port_reg    [N_MST];
    logic [SEL_W-1:0] port_next   [N_MST];
    logic [CNT_W-1:0] wr_cnt_reg  [N_MST];
    logic [CNT_W-1:0] wr_cnt_next [N_MST];
    logic [CNT_W-1:0] rd_cnt_reg  [N_MST];
    logic [CNT_W-1:0] rd_cnt_next [N_MST];
    logic [N_MST-1:0] conflict_reg, conflict_next;

    logic [SEL_W-1:0]  sel_in  [N_MST];
    logic [MOSI_W-1:0] mosi_in [N_MST];
    logic [MISO_W-1:0] miso_in [N_SLV];
    logic [MOSI_W-1:0] mosi_m  [N_MST];
    logic [MISO_W-1:0] miso_m  [N_MST];
    logic [MOSI_W-1:0] mosi_s  [N_SLV];
    logic [N_MST-1:0]  route, aw_hs, b_hs, ar_hs, rl_hs, blocked;

    genvar gi;
    generate
        for (gi = 0; gi < N_MST; gi++) begin : g_mst
            assign sel_in[gi]                        = sel_i[gi*SEL_W +: SEL_W];
            assign mosi_in[gi]                       = m_mosi_i[gi*MOSI_W +: MOSI_W];
            assign m_miso_o[gi*MISO_W +: MISO_W]     = miso_m[gi];
            assign bound_o[gi]                       = (state_reg[gi] != IDLE);
        end
        for (gi = 0; gi < N_SLV; gi++) begin : g_slv
            assign miso_in[gi]                       = s_miso_i[gi*MISO_W +: MISO_W];
            assign s_mosi_o[gi*MOSI_W +: MOSI_W]     = mosi_s[gi];
        end
    endgenerate

    assign conflict_o = conflict_reg;

    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            for (int m = 0; m < N_MST; m++) begin
                state_reg[m]  <= IDLE;
                port_reg[m]   <= '0;
                wr_cnt_reg[m] <= '0;
                rd_cnt_reg[m] <= '0;
            end
            conflict_reg <= '0;
        end else begin
            for (int m = 0; m < N_MST; m++) begin
                state_reg[m]  <= state_next[m];
                port_reg[m]   <= port_next[m];
                wr_cnt_reg[m] <= wr_cnt_next[m];
                rd_cnt_reg[m] <= rd_cnt_next[m];
            end
            conflict_reg <= conflict_next;
        end
    end

    always_comb begin
        conflict_next = conflict_reg;
        blocked       = '0;
        for (int m = 0; m < N_MST; m++) begin
            state_next[m]  = state_reg[m];
            port_next[m]   = port_reg[m];
            wr_cnt_next[m] = wr_cnt_reg[m];
            rd_cnt_next[m] = rd_cnt_reg[m];
            // A response arriving with nothing outstanding is dropped.
            if (aw_hs[m] && !b_hs[m])
                wr_cnt_next[m] = wr_cnt_reg[m] + CNT_W'(1);
            else if (b_hs[m] && !aw_hs[m] && wr_cnt_reg[m] != '0)
                wr_cnt_next[m] = wr_cnt_reg[m] - CNT_W'(1);
            if (ar_hs[m] && !rl_hs[m])
                rd_cnt_next[m] = rd_cnt_reg[m] + CNT_W'(1);
            else if (rl_hs[m] && !ar_hs[m] && rd_cnt_reg[m] != '0)
                rd_cnt_next[m] = rd_cnt_reg[m] - CNT_W'(1);
            for (int j = 0; j < N_MST; j++) begin
                if (j != m && state_reg[j] != IDLE && port_reg[j] == sel_in[m])
                    blocked[m] = 1'b1;
                if (j < m && state_reg[j] == IDLE && act_i[j] && sel_in[j] == sel_in[m])
                    blocked[m] = 1'b1;
            end
            case (state_reg[m])
                IDLE: begin
                    if (act_i[m]) begin
                        if (blocked[m]) begin
                            conflict_next[m] = 1'b1;
                        end else if (int'(sel_in[m]) < N_SLV) begin
                            state_next[m] = BOUND;
                            port_next[m]  = sel_in[m];
                        end
                    end
                end
                BOUND: begin
                    if (!act_i[m] || sel_in[m] != port_reg[m])
                        state_next[m] = (wr_cnt_next[m] != '0 || rd_cnt_next[m] != '0) ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (wr_cnt_next[m] == '0 && rd_cnt_next[m] == '0)
                        state_next[m] = IDLE;
                end
                default: state_next[m] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int m = 0; m < N_MST; m++) begin
            route[m]  = (state_reg[m] != IDLE) && !arst_axi;
            mosi_m[m] = route[m] ? mosi_in[m] : '0;
            miso_m[m] = route[m] ? miso_in[port_reg[m]] : '0;
            // New requests are held off while draining or once the outstanding limit is hit.
            if (state_reg[m] == DRAIN || wr_cnt_reg[m] == CNT_MAX) begin
                mosi_m[m][M_AWVALID] = 1'b0;
                miso_m[m][S_AWREADY] = 1'b0;
            end
            if (state_reg[m] == DRAIN || rd_cnt_reg[m] == CNT_MAX) begin
                mosi_m[m][M_ARVALID] = 1'b0;
                miso_m[m][S_ARREADY] = 1'b0;
            end
            aw_hs[m] = mosi_m[m][M_AWVALID] & miso_m[m][S_AWREADY];
            b_hs[m]  = miso_m[m][S_BVALID]  & mosi_m[m][M_BREADY];
            ar_hs[m] = mosi_m[m][M_ARVALID] & miso_m[m][S_ARREADY];
            rl_hs[m] = miso_m[m][S_RVALID]  & mosi_m[m][M_RREADY] & miso_m[m][S_RLAST];
        end
        for (int p = 0; p < N_SLV; p++) begin
            mosi_s[p] = '0;
            for (int m = 0; m < N_MST; m++) begin
                if (route[m] && int'(port_reg[m]) == p)
                    mosi_s[p] = mosi_s[p] | mosi_m[m];
            end
        end
    end

endmodule

// File: tb/tb_axi_port_mux.sv
// Bench for axi_port_mux: table vectors, directed multi-cycle sequences and random traffic,
// all cross-checked every cycle against a port-ownership model.
module tb_axi_port_mux;

    localparam int NM = 2, NS = 4, MAXO = 4, AW = 8, DW = 8;
    localparam int MW = 2 * AW + DW + 6;
    localparam int SW = DW + 8;
    localparam int B_RREADY = 0, B_ARVALID = AW + 1, B_BREADY = AW + 2, B_AWVALID = 2 * AW + DW + 5;
    localparam int B_RLAST = 0, B_RVALID = DW + 1, B_ARREADY = DW + 2, B_BVALID = DW + 5, B_AWREADY = DW + 7;
    localparam logic [MW-1:0] PAT0 = 30'h0ACE_1357;
    localparam logic [MW-1:0] PAT1 = 30'h1357_0ACE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       act;
    logic [1:0]       sel [NM];
    logic [MW-1:0]    mm  [NM];
    logic [SW-1:0]    sm  [NS];
    logic [2*2-1:0]   sel_flat;
    logic [NM*MW-1:0] mm_flat;
    logic [NS*SW-1:0] sm_flat;
    logic [NM*SW-1:0] m_miso;
    logic [NS*MW-1:0] s_mosi;
    logic [1:0]       bound, conflict;

    assign sel_flat = {sel[1], sel[0]};
    assign mm_flat  = {mm[1], mm[0]};
    assign sm_flat  = {sm[3], sm[2], sm[1], sm[0]};

    axi_port_mux #(.NOC_SIZE(NS), .N_MST(NM), .MAX_OUTSTD(MAXO), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_axi(clk), .arst_axi(rst), .act_i(act), .sel_i(sel_flat),
        .m_mosi_i(mm_flat), .m_miso_o(m_miso), .s_mosi_o(s_mosi), .s_miso_i(sm_flat),
        .bound_o(bound), .conflict_o(conflict)
    );

    // Model: who owns each port, which port each master holds, outstanding counts.
    int owner [NS];
    int mport [NM];
    bit drn   [NM];
    int wr    [NM];
    int rd    [NM];
    bit cf    [NM];
    int checks = 0, failures = 0, cyc = 0;

    task automatic cmp(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] fwd_req(int m);
        logic [MW-1:0] r = mm[m];
        if (drn[m] || wr[m] == MAXO) r[B_AWVALID] = 1'b0;
        if (drn[m] || rd[m] == MAXO) r[B_ARVALID] = 1'b0;
        return r;
    endfunction

    function automatic logic [SW-1:0] fwd_rsp(int m);
        logic [SW-1:0] r = sm[mport[m]];
        if (drn[m] || wr[m] == MAXO) r[B_AWREADY] = 1'b0;
        if (drn[m] || rd[m] == MAXO) r[B_ARREADY] = 1'b0;
        return r;
    endfunction

    task automatic model_check();
        logic [NS*MW-1:0] es;
        logic [NM*SW-1:0] em;
        logic [1:0] eb, ec;
        es = '0; em = '0;
        for (int p = 0; p < NS; p++)
            if (!rst && owner[p] >= 0) es[p*MW +: MW] = fwd_req(owner[p]);
        for (int m = 0; m < NM; m++) begin
            eb[m] = (mport[m] >= 0);
            ec[m] = cf[m];
            if (!rst && mport[m] >= 0) em[m*SW +: SW] = fwd_rsp(m);
        end
        cmp("model_s_mosi", 128'(s_mosi), 128'(es));
        cmp("model_m_miso", 128'(m_miso), 128'(em));
        cmp("model_bound", 128'(bound), 128'(eb));
        cmp("model_conflict", 128'(conflict), 128'(ec));
    endtask

    task automatic model_step();
        int nwr [NM];
        int nrd [NM];
        int claimed [NS];
        int own_old [NS];
        if (rst) begin
            foreach (owner[p]) owner[p] = -1;
            for (int m = 0; m < NM; m++) begin
                mport[m] = -1; drn[m] = 0; wr[m] = 0; rd[m] = 0; cf[m] = 0;
            end
            return;
        end
        for (int m = 0; m < NM; m++) begin
            nwr[m] = wr[m];
            nrd[m] = rd[m];
            if (mport[m] >= 0) begin
                logic [MW-1:0] q = fwd_req(m);
                logic [SW-1:0] s = fwd_rsp(m);
                bit a  = q[B_AWVALID] && s[B_AWREADY];
                bit b  = s[B_BVALID] && q[B_BREADY];
                bit ar = q[B_ARVALID] && s[B_ARREADY];
                bit r  = s[B_RVALID] && q[B_RREADY] && s[B_RLAST];
                if (a && !b) nwr[m]++; else if (b && !a && nwr[m] > 0) nwr[m]--;
                if (ar && !r) nrd[m]++; else if (r && !ar && nrd[m] > 0) nrd[m]--;
            end
        end
        own_old = owner;
        foreach (claimed[p]) claimed[p] = -1;
        for (int m = 0; m < NM; m++) begin
            if (mport[m] < 0) begin
                if (act[m]) begin
                    int p = int'(sel[m]);
                    if (own_old[p] >= 0 || claimed[p] >= 0) cf[m] = 1;
                    else claimed[p] = m;
                end
            end else begin
                bit leaving = !act[m] || int'(sel[m]) != mport[m];
                bit empty   = (nwr[m] == 0) && (nrd[m] == 0);
                if (!drn[m] && leaving && !empty) drn[m] = 1;
                else if ((drn[m] || leaving) && empty) begin
                    owner[mport[m]] = -1; mport[m] = -1; drn[m] = 0;
                end
            end
            wr[m] = nwr[m];
            rd[m] = nrd[m];
        end
        for (int p = 0; p < NS; p++)
            if (claimed[p] >= 0) begin owner[p] = claimed[p]; mport[claimed[p]] = p; end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        model_check();
    endtask

    task automatic clr_bus();
        for (int m = 0; m < NM; m++) mm[m] = '0;
        for (int p = 0; p < NS; p++) sm[p] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; act = 2'b00; clr_bus();
        step();
        rst = 1'b0;
    endtask

    task automatic bind0(int p);
        act = 2'b01; sel[0] = 2'(p);
        step();
        cmp("bind_m0", 128'(bound), 128'(2'b01));
    endtask

    function automatic logic miso_bit(int m, int b);
        return m_miso[m*SW + b];
    endfunction

    function automatic logic mosi_bit(int p, int b);
        return s_mosi[p*MW + b];
    endfunction

    typedef struct {
        logic       rst;
        logic [1:0] act;
        logic [1:0] s0, s1;
        int         port;
        int         src;
        logic [1:0] eb, ec;
    } vec_t;
    vec_t tbl [11];

    initial begin
        int c0;
        tbl[0]  = '{1'b1, 2'b00, 2'd0, 2'd0, 1, -1, 2'b00, 2'b00};
        tbl[1]  = '{1'b0, 2'b11, 2'd1, 2'd1, 1,  0, 2'b01, 2'b10};
        tbl[2]  = '{1'b0, 2'b11, 2'd1, 2'd1, 1,  0, 2'b01, 2'b10};
        tbl[3]  = '{1'b0, 2'b10, 2'd1, 2'd1, 1, -1, 2'b00, 2'b10};
        tbl[4]  = '{1'b0, 2'b10, 2'd1, 2'd1, 1,  1, 2'b10, 2'b10};
        tbl[5]  = '{1'b0, 2'b11, 2'd2, 2'd1, 2,  0, 2'b11, 2'b10};
        tbl[6]  = '{1'b0, 2'b11, 2'd2, 2'd3, 3, -1, 2'b01, 2'b10};
        tbl[7]  = '{1'b0, 2'b11, 2'd2, 2'd3, 3,  1, 2'b11, 2'b10};
        tbl[8]  = '{1'b0, 2'b11, 2'd3, 2'd3, 3,  1, 2'b10, 2'b10};
        tbl[9]  = '{1'b0, 2'b11, 2'd3, 2'd3, 3,  1, 2'b10, 2'b11};
        tbl[10] = '{1'b1, 2'b11, 2'd3, 2'd3, 3, -1, 2'b00, 2'b00};

        foreach (owner[p]) owner[p] = -1;
        for (int m = 0; m < NM; m++) begin
            mport[m] = -1; drn[m] = 0; wr[m] = 0; rd[m] = 0; cf[m] = 0; sel[m] = '0;
        end
        rst = 1'b1; act = '0; clr_bus();

        // Arbitration and ownership table
        for (int i = 0; i < 11; i++) begin
            logic [MW-1:0] exp_req;
            mm[0] = PAT0; mm[1] = PAT1;
            for (int p = 0; p < NS; p++) sm[p] = '0;
            rst = tbl[i].rst; act = tbl[i].act; sel[0] = tbl[i].s0; sel[1] = tbl[i].s1;
            step();
            exp_req = (tbl[i].src < 0) ? '0 : ((tbl[i].src == 0) ? PAT0 : PAT1);
            cmp("vec_bound", 128'(bound), 128'(tbl[i].eb));
            cmp("vec_conflict", 128'(conflict), 128'(tbl[i].ec));
            cmp("vec_port_req", 128'(s_mosi[tbl[i].port*MW +: MW]), 128'(exp_req));
            $display("vec %0d: act=%b sel=%0d/%0d bound=%b conflict=%b", i, act, sel[0], sel[1], bound, conflict);
        end

        // Bind, AW then B on port 2, release with no drain
        do_reset();
        bind0(2);
        mm[0][B_AWVALID] = 1'b1; mm[0][B_BREADY] = 1'b1; sm[2][B_AWREADY] = 1'b1;
        step();
        cmp("wr_aw_routed", 128'(mosi_bit(2, B_AWVALID)), 128'(1'b1));
        mm[0][B_AWVALID] = 1'b0; sm[2][B_AWREADY] = 1'b0; sm[2][B_BVALID] = 1'b1;
        step();
        sm[2][B_BVALID] = 1'b0; act = 2'b00;
        step();
        cmp("wr_release_direct", 128'(bound), 128'(2'b00));
        $display("seq write: bound=%b", bound);

        // Read saturation at MAX_OUTSTD
        do_reset();
        bind0(0);
        mm[0][B_ARVALID] = 1'b1; mm[0][B_RREADY] = 1'b1; sm[0][B_ARREADY] = 1'b1;
        repeat (4) step();
        cmp("rd_sat_arready", 128'(miso_bit(0, B_ARREADY)), 128'(1'b0));
        cmp("rd_sat_arvalid", 128'(mosi_bit(0, B_ARVALID)), 128'(1'b0));
        sm[0][B_RVALID] = 1'b1; sm[0][B_RLAST] = 1'b1;
        step();
        cmp("rd_arready_back", 128'(miso_bit(0, B_ARREADY)), 128'(1'b1));
        sm[0][B_RVALID] = 1'b0; sm[0][B_RLAST] = 1'b0;
        $display("seq read saturation: arready=%b", miso_bit(0, B_ARREADY));

        // Drain with two outstanding writes
        do_reset();
        bind0(1);
        mm[0][B_AWVALID] = 1'b1; mm[0][B_BREADY] = 1'b1; sm[1][B_AWREADY] = 1'b1;
        repeat (2) step();
        mm[0][B_AWVALID] = 1'b0; act = 2'b00;
        step();
        cmp("drain_bound", 128'(bound), 128'(2'b01));
        mm[0][B_AWVALID] = 1'b1;
        step();
        cmp("drain_aw_mask", 128'(mosi_bit(1, B_AWVALID)), 128'(1'b0));
        cmp("drain_awready_mask", 128'(miso_bit(0, B_AWREADY)), 128'(1'b0));
        mm[0][B_AWVALID] = 1'b0; sm[1][B_BVALID] = 1'b1;
        step();
        cmp("drain_one_left", 128'(bound), 128'(2'b01));
        step();
        cmp("drain_done", 128'(bound), 128'(2'b00));
        cmp("drain_port_zero", 128'(s_mosi[1*MW +: MW]), 128'(0));
        sm[1][B_BVALID] = 1'b0;
        $display("seq drain: bound=%b", bound);

        // Reset mid-burst
        do_reset();
        bind0(0);
        mm[0][B_ARVALID] = 1'b1; sm[0][B_ARREADY] = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        cmp("rst_bound", 128'(bound), 128'(2'b00));
        cmp("rst_s_mosi", 128'(s_mosi), 128'(0));
        cmp("rst_m_miso", 128'(m_miso), 128'(0));
        rst = 1'b0; act = 2'b00;
        step();
        cmp("post_rst_s_mosi", 128'(s_mosi), 128'(0));
        mm[0][B_ARVALID] = 1'b0; act = 2'b01;
        step();
        act = 2'b00;
        step();
        cmp("post_rst_cnt_zero", 128'(bound), 128'(2'b00));
        $display("seq reset: bound=%b", bound);

        // Same-cycle AW and B leave the write count unchanged
        do_reset();
        bind0(3);
        mm[0][B_AWVALID] = 1'b1; mm[0][B_BREADY] = 1'b1; sm[3][B_AWREADY] = 1'b1;
        repeat (2) step();
        sm[3][B_BVALID] = 1'b1;
        step();
        sm[3][B_BVALID] = 1'b0;
        step();
        cmp("same_cycle_cnt3", 128'(miso_bit(0, B_AWREADY)), 128'(1'b1));
        step();
        cmp("same_cycle_cnt4", 128'(miso_bit(0, B_AWREADY)), 128'(1'b0));
        $display("seq same-cycle: awready=%b", miso_bit(0, B_AWREADY));

        // Random traffic against the model
        do_reset();
        c0 = checks;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 255) == 0);
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 15) == 0) act[m] = ~act[m];
                if ($urandom_range(0, 15) == 0) sel[m] = 2'($urandom_range(0, 3));
                mm[m] = MW'($urandom);
            end
            for (int p = 0; p < NS; p++) sm[p] = SW'($urandom);
            step();
            if (i % 100 == 99)
                $display("random block %0d: bound=%b conflict=%b checks=%0d", i / 100, bound, conflict, checks - c0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
